// File: rtl/pattern_chk_pkg.sv
// Shared types and constants for the XCVR loopback pattern checker.
package pattern_chk_pkg;

  typedef enum logic [1:0] {HUNT, COMMA, SYNC, LOCKED} state_e;

  localparam logic [31:0] C_COMMA_DATA = 32'h0000_00BC;
  localparam logic [3:0]  C_COMMA_K    = 4'b0001;
  localparam logic [31:0] C_FIRST_WORD = 32'h0000_0001;
  localparam logic [31:0] C_ERR_WORD   = 32'hFFFF_FFEF;

  typedef struct packed {
    logic        valid;
    logic [3:0]  k;
    logic [31:0] data;
  } rx_word_t;

endpackage

// File: rtl/pattern_chk_if.sv
// RX lane bundle between the transceiver (master) and the checker (slave).
interface pattern_chk_if #(
  parameter int g_DATA_WID = 32
) ();
  logic [g_DATA_WID-1:0] rx_data_i;
  logic [3:0]            rx_k_char_i;
  logic                  rx_valid_i;

  modport master (output rx_data_i, rx_k_char_i, rx_valid_i);
  modport slave  (input  rx_data_i, rx_k_char_i, rx_valid_i);
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter; clear has priority over increment.
module sat_counter #(
  parameter int WID = 16
) (
  input  logic           clk_i,
  input  logic           reset_n_i,
  input  logic           inc_i,
  input  logic           clr_i,
  output logic [WID-1:0] cnt_o
);
  logic [WID-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                    cnt_d = '0;
    else if (inc_i && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/pattern_chk.sv
// Loopback RX checker: aligns to comma + incrementing count, locks, counts mismatches.
// PATTERN_CHK_STATS_EN builds the matched-word counter behind good_count_o.
module pattern_chk
  import pattern_chk_pkg::*;
#(
  parameter int g_DATA_WID    = 32,
  parameter int g_LOCK_CNT    = 4,
  parameter int g_UNLOCK_ERRS = 8,
  parameter int g_ERR_CNT_WID = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  pattern_chk_if.slave             rx,
  input  logic                     clear_err_i,
  output logic                     lock_o,
  output logic                     err_o,
  output logic [g_ERR_CNT_WID-1:0] err_count_o,
  output logic [31:0]              good_count_o
);
  localparam logic [3:0] LOCK_CNT = 4'(g_LOCK_CNT);
  localparam logic [3:0] UNLOCK   = 4'(g_UNLOCK_ERRS);

  rx_word_t              rx_q, rx_d;
  logic [1:0]            clr_sync_q, clr_sync_d;
  state_e                state_q, state_d;
  logic [g_DATA_WID-1:0] exp_q, exp_d;
  logic [3:0]            good_run_q, good_run_d, bad_run_q, bad_run_d;
  logic                  lock_q, lock_d, err_q, err_d;
  logic                  is_comma, is_first, is_match;

  always_comb begin
    rx_d       = '{valid: rx.rx_valid_i, k: rx.rx_k_char_i, data: rx.rx_data_i};
    clr_sync_d = {clr_sync_q[0], clear_err_i};
  end

  assign is_comma = (rx_q.k == C_COMMA_K) && (rx_q.data == C_COMMA_DATA);
  assign is_first = (rx_q.k == 4'b0000)   && (rx_q.data == C_FIRST_WORD);
  assign is_match = (rx_q.k == 4'b0000)   && (rx_q.data == exp_q);

  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    good_run_d = good_run_q;
    bad_run_d  = bad_run_q;
    err_d      = 1'b0;
    if (!rx_q.valid) begin
      state_d    = HUNT;
      good_run_d = '0;
      bad_run_d  = '0;
    end else begin
      unique case (state_q)
        HUNT:   if (is_comma) state_d = COMMA;
        COMMA: begin
          if (is_first) begin
            exp_d      = C_FIRST_WORD + 1'b1;
            good_run_d = 4'd1;
            state_d    = (LOCK_CNT == 4'd1) ? LOCKED : SYNC;
          end else if (!is_comma) begin
            state_d = HUNT;
          end
        end
        SYNC: begin
          if (is_match) begin
            good_run_d = good_run_q + 4'd1;
            exp_d      = exp_q + 1'b1;
            if (good_run_q + 4'd1 == LOCK_CNT) state_d = LOCKED;
          end else begin
            state_d    = HUNT;
            good_run_d = '0;
          end
        end
        LOCKED: begin
          // Advance on every word so one corrupted word costs exactly one error.
          exp_d = exp_q + 1'b1;
          if (is_match) begin
            bad_run_d = '0;
          end else begin
            err_d     = 1'b1;
            bad_run_d = bad_run_q + 4'd1;
            if (bad_run_q + 4'd1 == UNLOCK) begin
              state_d    = HUNT;
              bad_run_d  = '0;
              good_run_d = '0;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
    lock_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rx_q       <= '0;
      clr_sync_q <= '0;
      state_q    <= HUNT;
      exp_q      <= '0;
      good_run_q <= '0;
      bad_run_q  <= '0;
      lock_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rx_q       <= rx_d;
      clr_sync_q <= clr_sync_d;
      state_q    <= state_d;
      exp_q      <= exp_d;
      good_run_q <= good_run_d;
      bad_run_q  <= bad_run_d;
      lock_q     <= lock_d;
      err_q      <= err_d;
    end
  end

  assign lock_o = lock_q;
  assign err_o  = err_q;

  sat_counter #(.WID(g_ERR_CNT_WID)) u_err_cnt (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .inc_i     (err_d),
    .clr_i     (clr_sync_q[1]),
    .cnt_o     (err_count_o)
  );

`ifdef PATTERN_CHK_STATS_EN
  logic good_inc;
  assign good_inc = rx_q.valid && (state_q == LOCKED) && is_match;

  sat_counter #(.WID(32)) u_good_cnt (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .inc_i     (good_inc),
    .clr_i     (clr_sync_q[1]),
    .cnt_o     (good_count_o)
  );
`else
  assign good_count_o = '0;
`endif
endmodule
